// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared port IDs, owner record and reset values
// for the I/D memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e port;
  } owner_t;

  localparam owner_t OWNER_RST = '{valid: 1'b0, port: PORT_I};
  localparam port_e  PTR_RST   = PORT_D;

  function automatic port_e other_port(input port_e p);
    return (p == PORT_I) ? PORT_D : PORT_I;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection, one-hot {D, I}.
// Round-robin when MEM_ARB_RR_EN is defined, else D has priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       i_req_i,
  input  logic       d_req_i,
  input  port_e      ptr_i,
  output logic [1:0] gnt_o
);

  port_e pri;

`ifdef MEM_ARB_RR_EN
  assign pri = ptr_i;
`else
  logic unused_ptr;
  assign pri        = PORT_D;
  assign unused_ptr = ptr_i;
`endif

  always_comb begin
    gnt_o = 2'b00;
    unique case ({d_req_i, i_req_i})
      2'b11:   gnt_o = (pri == PORT_D) ? 2'b10 : 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b01:   gnt_o = 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-addressed memory between fetch (I)
// and load/store (D). Round-robin policy with MEM_ARB_RR_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int CNT_W     = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_i_req,
  input  logic [ADDR_W-1:0]            i_i_addr,
  output logic                         o_i_gnt,
  output logic                         o_i_rvalid,
  output logic [DATA_W-1:0]            o_i_rdata,
  input  logic                         i_d_req,
  input  logic                         i_d_wen,
  input  logic [ADDR_W-1:0]            i_d_addr,
  input  logic [DATA_W-1:0]            i_d_wdata,
  output logic                         o_d_gnt,
  output logic                         o_d_rvalid,
  output logic [DATA_W-1:0]            o_d_rdata,
  output logic                         o_m_en,
  output logic                         o_m_wen,
  output logic [$clog2(MEM_DEPTH)-1:0] o_m_addr,
  output logic [DATA_W-1:0]            o_m_wdata,
  input  logic [DATA_W-1:0]            i_m_rdata,
  output logic                         o_err,
  output logic [CNT_W-1:0]             o_conflict_cnt
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W:0] LIMIT =
    (ADDR_W+1)'(MEM_DEPTH) << 2;

  logic [1:0]        gnt;
  logic              req_i;
  logic              req_d;
  port_e             ptr;
  logic [ADDR_W-1:0] sel_addr;
  logic              any_gnt;
  logic              wr_gnt;
  logic              legal;
  logic              rv;
  owner_t            owner_q, owner_d;
  logic              bad_q, bad_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Nothing is granted while reset is held.
  assign req_i = i_i_req & ~i_rst;
  assign req_d = i_d_req & ~i_rst;

`ifdef MEM_ARB_RR_EN
  port_e ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0]) ptr_d = PORT_D;
    else if (gnt[1]) ptr_d = PORT_I;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) ptr_q <= PTR_RST;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = PTR_RST;
`endif

  mem_arb_pick u_pick (
    .i_req_i (req_i),
    .d_req_i (req_d),
    .ptr_i   (ptr),
    .gnt_o   (gnt)
  );

  assign o_i_gnt = gnt[0];
  assign o_d_gnt = gnt[1];

  always_comb begin
    sel_addr  = gnt[1] ? i_d_addr : i_i_addr;
    any_gnt   = |gnt;
    wr_gnt    = gnt[1] & i_d_wen;
    legal     = ({1'b0, sel_addr} < LIMIT) &&
                (sel_addr[1:0] == 2'b00);
    o_m_en    = any_gnt & legal;
    o_m_wen   = o_m_en & wr_gnt;
    o_m_addr  = o_m_en ? sel_addr[AW+1:2] : '0;
    o_m_wdata = o_m_wen ? i_d_wdata : '0;
    owner_d.valid = any_gnt & ~wr_gnt;
    owner_d.port  = gnt[1] ? PORT_D : PORT_I;
    // Illegal reads still answer, but with zero data.
    bad_d = owner_d.valid & ~legal;
    err_d = err_q | (any_gnt & ~legal);
    cnt_d = cnt_q;
    if (i_i_req && i_d_req && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      owner_q <= OWNER_RST;
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      owner_q <= owner_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rv         = owner_q.valid & ~i_rst;
  assign o_i_rvalid = rv & (owner_q.port == PORT_I);
  assign o_d_rvalid = rv & (owner_q.port == PORT_D);
  assign o_i_rdata  = (o_i_rvalid && !bad_q) ? i_m_rdata : '0;
  assign o_d_rdata  = (o_d_rvalid && !bad_q) ? i_m_rdata : '0;

  assign o_err          = err_q;
  assign o_conflict_cnt = cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a
// behavioural memory; expectations follow MEM_ARB_RR_EN.
module tb_mem_arbiter;

  typedef logic [44:0] grec_t;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_wen;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_en;
  logic        m_wen;
  logic [9:0]  m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        err;
  logic [15:0] ccnt;

  int    checks = 0;
  int    errors = 0;
  logic  chk_en = 1'b1;
  grec_t gq[$];
  logic [31:0] iq[$];
  logic [31:0] dq[$];
  logic [31:0] mem [1024];

`ifdef MEM_ARB_RR_EN
  localparam logic [63:0] EXP_CONF = 64'd7;
`else
  localparam logic [63:0] EXP_CONF = 64'd4;
`endif

  mem_arbiter dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_i_req        (i_req),
    .i_i_addr       (i_addr),
    .o_i_gnt        (i_gnt),
    .o_i_rvalid     (i_rvalid),
    .o_i_rdata      (i_rdata),
    .i_d_req        (d_req),
    .i_d_wen        (d_wen),
    .i_d_addr       (d_addr),
    .i_d_wdata      (d_wdata),
    .o_d_gnt        (d_gnt),
    .o_d_rvalid     (d_rvalid),
    .o_d_rdata      (d_rdata),
    .o_m_en         (m_en),
    .o_m_wen        (m_wen),
    .o_m_addr       (m_addr),
    .o_m_wdata      (m_wdata),
    .i_m_rdata      (m_rdata),
    .o_err          (err),
    .o_conflict_cnt (ccnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns garbage when not read, so the DUT must zero it.
  always @(posedge clk) begin
    m_rdata <= (m_en && !m_wen) ? mem[m_addr] : 32'hBAD0_BAD0;
    if (m_en && m_wen) mem[m_addr] = m_wdata;
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic grec_t mk(input logic d, input logic en,
                               input logic wen,
                               input logic [9:0] a,
                               input logic [31:0] wd);
    return {d, en, wen, a, wd};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("gnt_excl", 64'(i_gnt & d_gnt), 64'd0);
      if (i_gnt || d_gnt) begin
        if (gq.size() == 0)
          chk("gnt_unexp", 64'({i_gnt, d_gnt}), 64'd0);
        else
          chk("gnt", 64'({d_gnt, m_en, m_wen, m_addr, m_wdata}),
              64'(gq.pop_front()));
      end
      if (i_rvalid) begin
        if (iq.size() == 0)
          chk("i_rvalid_unexp", 64'(i_rvalid), 64'd0);
        else
          chk("i_rdata", 64'(i_rdata), 64'(iq.pop_front()));
      end else begin
        chk("i_rdata_idle", 64'(i_rdata), 64'd0);
      end
      if (d_rvalid) begin
        if (dq.size() == 0)
          chk("d_rvalid_unexp", 64'(d_rvalid), 64'd0);
        else
          chk("d_rdata", 64'(d_rdata), 64'(dq.pop_front()));
      end else begin
        chk("d_rdata_idle", 64'(d_rdata), 64'd0);
      end
    end
  end

  task automatic drive(input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw,
                       input logic [31:0] da,
                       input logic [31:0] dd);
    i_req   = ir;
    i_addr  = ia;
    d_req   = dr;
    d_wen   = dw;
    d_addr  = da;
    d_wdata = dd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_gnt"}, 64'({i_gnt, d_gnt}), 64'd0);
    chk({tag, "_rv"}, 64'({i_rvalid, d_rvalid}), 64'd0);
    chk({tag, "_rdata"}, {i_rdata, d_rdata}, 64'd0);
    chk({tag, "_m"}, 64'({m_en, m_wen, m_addr, m_wdata}), 64'd0);
  endtask

  logic [31:0] ia_l [4];
  logic        dw_l [4];
  logic [31:0] da_l [4];
  logic [31:0] dd_l [4];

  initial begin
    int ii;
    int di;
    int n;
    logic gi;
    logic gd;
    for (int k = 0; k < 1024; k++) mem[k] = 32'hA000_0000 + k;
    mem[4] = 32'hDEAD_BEEF;
    idle();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outs("rst0");
    chk("rst0_err", 64'(err), 64'd0);
    chk("rst0_cnt", 64'(ccnt), 64'd0);
    step();

    // I-only read of 0x10
    gq.push_back(mk(1'b0, 1'b1, 1'b0, 10'd4, 32'h0));
    iq.push_back(32'hDEAD_BEEF);
    drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    idle();
    @(negedge clk);
    chk("i_only_d_rv", 64'(d_rvalid), 64'd0);
    step();

    // Contention: D write 0x20 then three reads, I fetching.
    ia_l = '{32'h0, 32'h4, 32'h8, 32'hC};
    dw_l = '{1'b1, 1'b0, 1'b0, 1'b0};
    da_l = '{32'h20, 32'h20, 32'h24, 32'h28};
    dd_l = '{32'h1234_5678, 32'h0, 32'h0, 32'h0};
`ifdef MEM_ARB_RR_EN
    gq.push_back(mk(1'b1, 1'b1, 1'b1, 10'd8, 32'h1234_5678));
    gq.push_back(mk(1'b0, 1'b1, 1'b0, 10'd0, 32'h0));
    gq.push_back(mk(1'b1, 1'b1, 1'b0, 10'd8, 32'h0));
    gq.push_back(mk(1'b0, 1'b1, 1'b0, 10'd1, 32'h0));
    gq.push_back(mk(1'b1, 1'b1, 1'b0, 10'd9, 32'h0));
    gq.push_back(mk(1'b0, 1'b1, 1'b0, 10'd2, 32'h0));
    gq.push_back(mk(1'b1, 1'b1, 1'b0, 10'd10, 32'h0));
    gq.push_back(mk(1'b0, 1'b1, 1'b0, 10'd3, 32'h0));
    iq.push_back(32'hA000_0000);
    iq.push_back(32'hA000_0001);
    iq.push_back(32'hA000_0002);
    iq.push_back(32'hA000_0003);
`else
    gq.push_back(mk(1'b1, 1'b1, 1'b1, 10'd8, 32'h1234_5678));
    gq.push_back(mk(1'b1, 1'b1, 1'b0, 10'd8, 32'h0));
    gq.push_back(mk(1'b1, 1'b1, 1'b0, 10'd9, 32'h0));
    gq.push_back(mk(1'b1, 1'b1, 1'b0, 10'd10, 32'h0));
    gq.push_back(mk(1'b0, 1'b1, 1'b0, 10'd0, 32'h0));
    iq.push_back(32'hA000_0000);
`endif
    dq.push_back(32'h1234_5678);
    dq.push_back(32'hA000_0009);
    dq.push_back(32'hA000_000A);
    ii = 0;
    di = 0;
    n  = 0;
    while (di < 4 && n < 20) begin
      drive(1'b1, ia_l[ii[1:0]], 1'b1, dw_l[di[1:0]],
            da_l[di[1:0]], dd_l[di[1:0]]);
      @(negedge clk);
      gi = i_gnt;
      gd = d_gnt;
      step();
      if (gi) ii++;
      if (gd) di++;
      n++;
    end
    chk("contention_done", 64'(di), 64'd4);
    drive(1'b1, ia_l[ii[1:0]], 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    idle();
    @(negedge clk);
    chk("conflict_cnt", 64'(ccnt), EXP_CONF);
    step();

    // D write 0x55 to 0x40, read it back.
    gq.push_back(mk(1'b1, 1'b1, 1'b1, 10'd16, 32'h55));
    gq.push_back(mk(1'b1, 1'b1, 1'b0, 10'd16, 32'h0));
    dq.push_back(32'h55);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h55);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
    step();
    idle();
    step();

    // Illegal reads and write, then legal boundary reads.
    gq.push_back(mk(1'b1, 1'b0, 1'b0, 10'd0, 32'h0));
    gq.push_back(mk(1'b1, 1'b0, 1'b0, 10'd0, 32'h0));
    gq.push_back(mk(1'b1, 1'b0, 1'b0, 10'd0, 32'h0));
    gq.push_back(mk(1'b1, 1'b0, 1'b0, 10'd0, 32'h0));
    gq.push_back(mk(1'b1, 1'b1, 1'b0, 10'd1, 32'h0));
    gq.push_back(mk(1'b1, 1'b1, 1'b0, 10'd1023, 32'h0));
    dq.push_back(32'h0);
    dq.push_back(32'h0);
    dq.push_back(32'h0);
    dq.push_back(32'hA000_0001);
    dq.push_back(32'hA000_03FF);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h1002, 32'h0);
    @(negedge clk);
    chk("err_before", 64'(err), 64'd0);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h1000, 32'h0);
    @(negedge clk);
    chk("err_set", 64'(err), 64'd1);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h42, 32'h0);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h1004, 32'hFFFF);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'hFFC, 32'h0);
    step();
    idle();
    repeat (3) step();
    @(negedge clk);
    chk("err_held", 64'(err), 64'd1);
    step();

    // Reset in the cycle after an I read grant.
    gq.push_back(mk(1'b0, 1'b1, 1'b0, 10'd4, 32'h0));
    drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs("rst_mid");
    step();
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk_reset_outs("rst_after");
    chk("rst_after_err", 64'(err), 64'd0);
    chk("rst_after_cnt", 64'(ccnt), 64'd0);
    step();
    step();
    chk("gq_empty", 64'(gq.size()), 64'd0);
    chk("iq_empty", 64'(iq.size()), 64'd0);
    chk("dq_empty", 64'(dq.size()), 64'd0);

    // Counter saturation.
    chk_en = 1'b0;
    drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    repeat (65541) step();
    idle();
    @(negedge clk);
    chk("cnt_sat", 64'(ccnt), 64'hFFFF);
    step();
    @(negedge clk);
    chk("cnt_sat_hold", 64'(ccnt), 64'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
